qtr_sample_scheduler: RTL and testbench
=======================================

Name: qtr_sample_scheduler

Overview:
Periodic scheduler and result manager for the QTR line-sensor averaging datapath (the start/end-of-process sensor-read plus SAR-divide chain).
- Issues a one-cycle start pulse every PERIOD cycles and waits for end-of-process, with a timeout.
- Latches the 11-bit weighted-position result and publishes it to the steering/PID consumer through a valid/ack handshake.
- Detects lost-line: zero active sensors, which is also a divide-by-zero case.

Parameters:
PER_W, 20, width of the sample period counter
PERIOD, 24000, cycles between start pulses (1 ms at 24 MHz); legal range 2..2^PER_W-1
TO_CYC, 4095, maximum cycles to wait for end-of-process after the start pulse
LOST_MAX, 3, consecutive zero-sensor samples before line_lost asserts
RES_W, 11, result width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
en  in  1  scheduler enable, level
clr  in  1  one-cycle pulse; clears sticky flags timeout_err, overrun, tick_miss
eop  in  1  end-of-process from the averaging datapath; rising edge is significant
sn_cnt  in  5  number of active sensors from the held count register; valid when eop rises
res  in  RES_W  divider result; valid when eop rises
ack  in  1  consumer acknowledge of pos_vld
stp  out  1  start pulse to the datapath, exactly 1 cycle wide
pos  out  RES_W  last valid line position
pos_vld  out  1  new sample available; held until ack
line_lost  out  1  LOST_MAX or more consecutive zero-sensor samples
timeout_err  out  1  sticky; eop not seen within TO_CYC cycles
overrun  out  1  sticky; a new sample was published while pos_vld was still high
tick_miss  out  1  sticky; a period tick arrived while a measurement was in flight
busy  out  1  high from the stp cycle until return to WAIT_TICK or IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; period counter, timeout counter and lost counter 0; eop edge register 0.
- Period counter:
  - Cleared while en=0.
  - Counts 0..PERIOD-1 and wraps while en=1.
  - tick is high when the count equals PERIOD-1.
  - The first tick occurs PERIOD cycles after the first edge that samples en=1.
- eop edge detect: eop_r registered each cycle; eop_rise = eop & ~eop_r.
- FSM:
  - IDLE: if en=1, go to WAIT_TICK.
  - WAIT_TICK:
    - If en=0, go to IDLE.
    - Else on tick, go to START.
  - START: stp=1 for this single cycle; timeout counter cleared; go to WAIT_EOP.
  - WAIT_EOP:
    - Timeout counter increments each cycle.
    - On eop_rise, go to LATCH.
    - Else when the counter reaches TO_CYC: set timeout_err, go to WAIT_TICK (no publish, pos unchanged).
    - eop_rise has priority over timeout in the same cycle.
  - LATCH (1 cycle):
    - sn_cnt != 0: pos <= res; lost counter cleared; line_lost <= 0.
    - sn_cnt == 0: pos is held. The lost counter increments and saturates at LOST_MAX. When the counter reaches LOST_MAX, line_lost <= 1.
    - In both cases pos_vld <= 1. If pos_vld was already 1 and ack is not high this cycle, overrun <= 1.
    - Next state: WAIT_TICK if en=1, else IDLE.
- tick while in START, WAIT_EOP or LATCH: the tick is ignored (no queuing) and tick_miss <= 1.
- Handshake: pos_vld falls on the cycle after ack=1 is sampled while pos_vld=1. An ack on the same cycle that LATCH sets pos_vld: the set wins. ack while pos_vld=0 is ignored.
- en=0 mid-measurement: the current measurement completes (publish or timeout), then the FSM goes to IDLE. No new stp is issued.
- clr clears the sticky flags. If clr coincides with a setting event, the set wins.
- line_lost and pos are not affected by clr.
- busy = 1 in states START, WAIT_EOP and LATCH.
- Latency: eop_rise at cycle N gives pos/pos_vld updated at edge N+2 (one cycle in LATCH).

Test Plan:
1. PERIOD=100, en=1 from cycle 0; datapath model returns eop 20 cycles after stp with res=500, sn_cnt=4 -> stp at cycle 100 and 200, each 1 cycle wide; pos=500, pos_vld=1 two cycles after eop; ack clears pos_vld next cycle.
2. Model never raises eop, TO_CYC=50 -> timeout_err=1 at stp+51, pos_vld stays 0, next stp still at the next tick. clr pulse -> timeout_err=0.
3. Three samples with sn_cnt=0 after a valid pos=300, LOST_MAX=3 -> pos stays 300, pos_vld for each sample, line_lost=1 after the third. A fourth sample with sn_cnt=2, res=410 -> line_lost=0, pos=410.
4. No ack across two samples (res 100 then 200) -> overrun=1, pos=200, pos_vld=1. Repeat with ack on the LATCH cycle -> pos_vld remains 1.
5. Model eop delay 150 with PERIOD=100 -> tick_miss=1; stp issued only on ticks seen in WAIT_TICK (no back-to-back stp).
6. Drop en during WAIT_EOP, then eop arrives -> sample published, FSM to IDLE, no further stp. Assert rst=0 mid-WAIT_EOP -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/qtr_sample_scheduler_if.sv
// -----------------------------------------------------------------------------
// qtr_sample_scheduler_if
//   Bundles the two handshakes of the QTR sample scheduler:
//     - datapath side : stp (start pulse out), eop / sn_cnt / res (results in)
//     - consumer side : pos / pos_vld (published sample out), ack (consumer in)
//   master : the scheduler (drives stp, pos, pos_vld)
//   slave  : datapath + steering consumer (drive eop, sn_cnt, res, ack)
// -----------------------------------------------------------------------------
interface qtr_sample_scheduler_if #(
    parameter int RES_W = 11
);
    logic             stp;
    logic             eop;
    logic [4:0]       sn_cnt;
    logic [RES_W-1:0] res;
    logic [RES_W-1:0] pos;
    logic             pos_vld;
    logic             ack;

    modport master (
        output stp, pos, pos_vld,
        input  eop, sn_cnt, res, ack
    );

    modport slave (
        input  stp, pos, pos_vld,
        output eop, sn_cnt, res, ack
    );
endinterface

// File: rtl/qtr_sample_scheduler.sv
// -----------------------------------------------------------------------------
// qtr_sample_scheduler
//   Periodic scheduler and result manager for the QTR line-sensor averaging
//   datapath. Every PERIOD cycles it fires a one-cycle start pulse, waits for
//   the end-of-process rising edge (bounded by TO_CYC cycles), latches the
//   weighted-position result and publishes it through a valid/ack handshake.
//   A run of LOST_MAX zero-sensor samples raises line_lost.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   en           scheduler enable (level)
//   clr          one-cycle pulse clearing timeout_err, overrun, tick_miss
//   bus          datapath / consumer handshake (see qtr_sample_scheduler_if)
//   line_lost    LOST_MAX or more consecutive zero-sensor samples
//   timeout_err  sticky: eop not seen within TO_CYC cycles
//   overrun      sticky: sample published while pos_vld still pending
//   tick_miss    sticky: period tick arrived during a measurement
//   busy         high in START, WAIT_EOP and LATCH
// -----------------------------------------------------------------------------
module qtr_sample_scheduler #(
    parameter int PER_W    = 20,
    parameter int PERIOD   = 24000,
    parameter int TO_CYC   = 4095,
    parameter int LOST_MAX = 3,
    parameter int RES_W    = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    qtr_sample_scheduler_if.master  bus,
    output logic                    line_lost,
    output logic                    timeout_err,
    output logic                    overrun,
    output logic                    tick_miss,
    output logic                    busy
);

    localparam int TO_W   = $clog2(TO_CYC + 1);
    localparam int LOST_W = $clog2(LOST_MAX + 1);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_CYC - 1);
    localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_MAX);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        START,
        WAIT_EOP,
        LATCH
    } state_e;

    state_e            state_q, state_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d;
    logic              eop_q, eop_d;
    logic [RES_W-1:0]  pos_q, pos_d;
    logic              pos_vld_q, pos_vld_d;
    logic              line_lost_q, line_lost_d;
    logic              timeout_err_q, timeout_err_d;
    logic              overrun_q, overrun_d;
    logic              tick_miss_q, tick_miss_d;

    logic tick;
    logic eop_rise;
    logic in_flight;

    assign tick      = (per_cnt_q == PER_LAST);
    assign eop_rise  = bus.eop & ~eop_q;
    assign in_flight = (state_q == START) || (state_q == WAIT_EOP) || (state_q == LATCH);

    // NOTE: every signal gets its default before the case statement, so no
    // path through this block leaves a value unassigned and no latch is built.
    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        lost_cnt_d    = lost_cnt_q;
        eop_d         = bus.eop;
        pos_d         = pos_q;
        pos_vld_d     = pos_vld_q;
        line_lost_d   = line_lost_q;
        // Sticky flags: clr clears, any set below overrides the clear.
        timeout_err_d = timeout_err_q & ~clr;
        overrun_d     = overrun_q & ~clr;
        tick_miss_d   = tick_miss_q & ~clr;

        // Free-running period counter, held at zero while disabled.
        if (!en || tick) per_cnt_d = '0;
        else             per_cnt_d = per_cnt_q + 1'b1;

        if (pos_vld_q && bus.ack) pos_vld_d = 1'b0;

        // Ticks are never queued; one landing mid-measurement is only flagged.
        if (tick && in_flight) tick_miss_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (en) state_d = WAIT_TICK;
            end

            WAIT_TICK: begin
                if (!en)       state_d = IDLE;
                else if (tick) state_d = START;
            end

            START: begin
                to_cnt_d = '0;
                state_d  = WAIT_EOP;
            end

            WAIT_EOP: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // eop_rise is tested first so it beats a same-cycle timeout.
                if (eop_rise) begin
                    state_d = LATCH;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = WAIT_TICK;
                end
            end

            LATCH: begin
                // Setting pos_vld here overrides a same-cycle ack clear above.
                pos_vld_d = 1'b1;
                if (pos_vld_q && !bus.ack) overrun_d = 1'b1;
                if (bus.sn_cnt != 5'd0) begin
                    pos_d       = bus.res;
                    lost_cnt_d  = '0;
                    line_lost_d = 1'b0;
                end else begin
                    // Zero sensors means divide-by-zero: keep last good pos.
                    if (lost_cnt_q != LOST_LAST) lost_cnt_d = lost_cnt_q + 1'b1;
                    if (lost_cnt_d == LOST_LAST) line_lost_d = 1'b1;
                end
                state_d = en ? WAIT_TICK : IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            per_cnt_q     <= '0;
            to_cnt_q      <= '0;
            lost_cnt_q    <= '0;
            eop_q         <= 1'b0;
            pos_q         <= '0;
            pos_vld_q     <= 1'b0;
            line_lost_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            tick_miss_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            to_cnt_q      <= to_cnt_d;
            lost_cnt_q    <= lost_cnt_d;
            eop_q         <= eop_d;
            pos_q         <= pos_d;
            pos_vld_q     <= pos_vld_d;
            line_lost_q   <= line_lost_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
            tick_miss_q   <= tick_miss_d;
        end
    end

    assign bus.stp     = (state_q == START);
    assign bus.pos     = pos_q;
    assign bus.pos_vld = pos_vld_q;
    assign line_lost   = line_lost_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;
    assign tick_miss   = tick_miss_q;
    assign busy        = in_flight;

endmodule

// File: tb/tb_qtr_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_qtr_sample_scheduler
//   Directed + randomized bench for qtr_sample_scheduler. The bench plays the
//   averaging datapath and the steering consumer, and predicts every output
//   from sample-level rules: start pulses on a fixed PERIOD grid, per-sample
//   publish/timeout outcome, last good position, run length of zero-sensor
//   samples and the sticky flags.
// -----------------------------------------------------------------------------
module tb_qtr_sample_scheduler;

    localparam int PER_W    = 8;
    localparam int PERIOD   = 100;
    localparam int TO_CYC   = 120;
    localparam int LOST_MAX = 3;
    localparam int RES_W    = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic line_lost, timeout_err, overrun, tick_miss, busy;

    qtr_sample_scheduler_if #(.RES_W(RES_W)) bus_if ();

    qtr_sample_scheduler #(
        .PER_W    (PER_W),
        .PERIOD   (PERIOD),
        .TO_CYC   (TO_CYC),
        .LOST_MAX (LOST_MAX),
        .RES_W    (RES_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clr         (clr),
        .bus         (bus_if),
        .line_lost   (line_lost),
        .timeout_err (timeout_err),
        .overrun     (overrun),
        .tick_miss   (tick_miss),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen so far; read at falling edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [RES_W-1:0] exp_pos  = '0;
    bit               exp_vld  = 1'b0;
    bit               exp_lost = 1'b0;
    bit               exp_to   = 1'b0;
    bit               exp_ov   = 1'b0;
    bit               exp_tm   = 1'b0;
    int               zero_run = 0;
    int               next_stp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ne();
        @(negedge clk);
    endtask

    // Returns the edge after which stp was first seen high (-1 if never).
    task automatic wait_stp(output int se);
        int n;
        n  = 0;
        se = -1;
        while (bus_if.stp !== 1'b1 && n < 3 * PERIOD) begin
            ne();
            n++;
        end
        if (bus_if.stp === 1'b1) se = cyc;
        check("stp_edge", se, next_stp);
    endtask

    // One measurement. d = eop delay after stp (0 = eop never comes).
    // ack_mode: 0 no ack, 1 ack after publish, 2 ack during the latch cycle.
    task automatic do_sample(input int d, input logic [RES_W-1:0] r,
                             input logic [4:0] s, input int ack_mode);
        int se;
        int s_exp;
        int f;
        s_exp = next_stp;
        wait_stp(se);
        ne();
        check("stp_width", bus_if.stp, 1'b0);
        check("busy_meas", busy, 1'b1);
        if (d == 0) begin
            repeat (TO_CYC - 1) ne();
            check("timeout_early", timeout_err, exp_to);
            ne();
            exp_to = 1'b1;
            f = s_exp + TO_CYC + 1;
            check("timeout_err", timeout_err, 1'b1);
            check("timeout_vld", bus_if.pos_vld, exp_vld);
            check("timeout_pos", bus_if.pos, exp_pos);
            check("busy_after_to", busy, 1'b0);
        end else begin
            repeat (d - 1) ne();
            bus_if.eop    = 1'b1;
            bus_if.res    = r;
            bus_if.sn_cnt = s;
            ne();
            check("busy_latch", busy, 1'b1);
            check("vld_before_pub", bus_if.pos_vld, exp_vld);
            if (ack_mode == 2) bus_if.ack = 1'b1;
            ne();
            bus_if.ack = 1'b0;
            bus_if.eop = 1'b0;
            if (exp_vld && ack_mode != 2) exp_ov = 1'b1;
            exp_vld = 1'b1;
            if (s != 5'd0) begin
                exp_pos  = r;
                zero_run = 0;
            end else begin
                zero_run++;
            end
            exp_lost = (zero_run >= LOST_MAX);
            f = s_exp + d + 2;
            check("pos", bus_if.pos, exp_pos);
            check("pos_vld", bus_if.pos_vld, 1'b1);
            check("line_lost", line_lost, exp_lost);
            check("overrun", overrun, exp_ov);
            check("busy_after_pub", busy, 1'b0);
        end
        // Next start: first grid point whose tick is seen back in WAIT_TICK.
        next_stp = s_exp + PERIOD * ((f - s_exp) / PERIOD + 1);
        if (next_stp - s_exp > PERIOD) exp_tm = 1'b1;
        check("tick_miss", tick_miss, exp_tm);
        if (ack_mode == 1) begin
            bus_if.ack = 1'b1;
            ne();
            bus_if.ack = 1'b0;
            exp_vld = 1'b0;
            check("ack_clears_vld", bus_if.pos_vld, 1'b0);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        ne();
        clr = 1'b0;
        exp_to = 1'b0;
        exp_ov = 1'b0;
        exp_tm = 1'b0;
        check("clr_timeout", timeout_err, 1'b0);
        check("clr_overrun", overrun, 1'b0);
        check("clr_tick_miss", tick_miss, 1'b0);
        check("clr_keeps_pos", bus_if.pos, exp_pos);
        check("clr_keeps_lost", line_lost, exp_lost);
    endtask

    initial begin
        int se;
        int n_stp;
        logic [RES_W-1:0] r;
        logic [4:0]       s;

        bus_if.eop    = 1'b0;
        bus_if.res    = '0;
        bus_if.sn_cnt = '0;
        bus_if.ack    = 1'b0;

        // Reset state.
        ne();
        ne();
        check("rst_stp", bus_if.stp, 1'b0);
        check("rst_pos", bus_if.pos, '0);
        check("rst_vld", bus_if.pos_vld, 1'b0);
        check("rst_lost", line_lost, 1'b0);
        check("rst_to", timeout_err, 1'b0);
        check("rst_ov", overrun, 1'b0);
        check("rst_tm", tick_miss, 1'b0);
        check("rst_busy", busy, 1'b0);

        // First stp after PERIOD-1 edges following the first enabled edge.
        rst = 1'b1;
        en  = 1'b1;
        next_stp = cyc + PERIOD;

        // Basic periodic publish with ack.
        do_sample(20, 11'd500, 5'd4, 1);
        do_sample(20, 11'($urandom_range(0, 2047)), 5'($urandom_range(1, 31)), 1);

        // Missing eop: timeout, no publish, next start still on the grid.
        do_sample(0, '0, '0, 0);
        pulse_clr();
        do_sample(15, 11'($urandom_range(0, 2047)), 5'd7, 1);

        // Lost-line run and recovery.
        do_sample(20, 11'd300, 5'd5, 1);
        for (int i = 0; i < LOST_MAX; i++)
            do_sample(20, 11'($urandom_range(0, 2047)), 5'd0, 1);
        do_sample(20, 11'd410, 5'd2, 1);

        // Overrun without ack, then an ack on the latch cycle.
        do_sample(20, 11'd100, 5'd3, 0);
        do_sample(20, 11'd200, 5'd3, 0);
        pulse_clr();
        check("vld_kept_by_clr", bus_if.pos_vld, 1'b1);
        do_sample(25, 11'($urandom_range(0, 2047)), 5'd9, 2);

        // Randomized samples.
        for (int i = 0; i < 10; i++) begin
            r = 11'($urandom_range(0, 2047));
            s = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            do_sample($urandom_range(1, 60), r, s, $urandom_range(0, 2));
        end

        // Long conversion overlapping the next tick.
        pulse_clr();
        do_sample(110, 11'd777, 5'd6, 1);
        do_sample(20, 11'd123, 5'd6, 1);

        // Disable mid-measurement: sample still published, then no more stp.
        wait_stp(se);
        repeat (5) ne();
        en = 1'b0;
        repeat (15) ne();
        r = 11'($urandom_range(1, 2047));
        bus_if.eop    = 1'b1;
        bus_if.res    = r;
        bus_if.sn_cnt = 5'd3;
        ne();
        ne();
        bus_if.eop = 1'b0;
        if (exp_vld) exp_ov = 1'b1;
        exp_vld = 1'b1;
        exp_pos = r;
        zero_run = 0;
        exp_lost = 1'b0;
        check("dis_pos", bus_if.pos, exp_pos);
        check("dis_vld", bus_if.pos_vld, 1'b1);
        check("dis_busy", busy, 1'b0);
        n_stp = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            ne();
            if (bus_if.stp === 1'b1) n_stp++;
        end
        check("dis_no_stp", n_stp, 0);
        check("dis_tick_miss", tick_miss, exp_tm);

        // Async reset in the middle of a measurement.
        en = 1'b1;
        next_stp = cyc + PERIOD;
        wait_stp(se);
        repeat (3) ne();
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_vld", bus_if.pos_vld, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_stp", bus_if.stp, 1'b0);
        check("arst_pos", bus_if.pos, '0);
        check("arst_vld", bus_if.pos_vld, 1'b0);
        check("arst_lost", line_lost, 1'b0);
        check("arst_to", timeout_err, 1'b0);
        check("arst_ov", overrun, 1'b0);
        check("arst_tm", tick_miss, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
